// File: rtl/battleship_pkg.sv
// Shared board geometry, hit-checker state encoding and guess helpers.
package battleship_pkg;

  localparam int CELLS = 28;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    SETUP = 2'd0,
    WAIT  = 2'd1,
    EVAL  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
  function automatic logic is_onehot(input logic [CELLS-1:0] x);
    return (x != '0) && ((x & (x - CELLS'(1))) == '0);
  endfunction

endpackage

// File: rtl/c_hit_checker_popcount_cells.sv
// popcount_cells: combinational population count of a CELLS-bit board map.
module popcount_cells
  import battleship_pkg::*;
(
  input  logic [CELLS-1:0] bits,
  output logic [CNT_W-1:0] count
);

  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < CELLS; i++) begin
      count = count + CNT_W'(bits[i]);
    end
  end

endmodule

// File: rtl/c_hit_checker.sv
// c_hit_checker: evaluates one-hot computer guesses against the latched ship map.
// Optional best-streak tracking is enabled with `define C_HIT_CHECKER_STREAK_EN.
module c_hit_checker
  import battleship_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             phase,
  input  logic [CELLS-1:0] ship_map,
  input  logic             guess_valid,
  input  logic [CELLS-1:0] sing_guess,
  output logic             busy,
  output logic             result_valid,
  output logic             hit,
  output logic             repeat_guess,
  output logic             err_onehot,
  output logic [CELLS-1:0] hit_map,
  output logic [CELLS-1:0] miss_map,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic             game_over
`ifdef C_HIT_CHECKER_STREAK_EN
  ,
  output logic [CNT_W-1:0] best_streak
`endif
);

  state_t           state, state_next;
  logic [CELLS-1:0] ship_reg;
  logic [CELLS-1:0] g_reg;
  logic [CNT_W-1:0] ship_total;
  logic [CNT_W-1:0] ship_pop;

  logic             clear;
  logic             capture;
  logic             set_err;
  logic             eval;

  logic             is_repeat;
  logic             is_hit;
  logic [CNT_W-1:0] hit_cnt_inc;
  logic [CNT_W-1:0] miss_cnt_inc;
  logic [CNT_W-1:0] hit_cnt_upd;

  popcount_cells u_popcount (
    .bits  (ship_map),
    .count (ship_pop)
  );

  always_comb begin
    is_repeat    = |(g_reg & (hit_map | miss_map));
    is_hit       = !is_repeat && |(g_reg & ship_reg);
    hit_cnt_inc  = (hit_cnt  < CNT_W'(CELLS)) ? hit_cnt  + CNT_W'(1) : hit_cnt;
    miss_cnt_inc = (miss_cnt < CNT_W'(CELLS)) ? miss_cnt + CNT_W'(1) : miss_cnt;
    hit_cnt_upd  = is_hit ? hit_cnt_inc : hit_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SETUP;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    clear      = 1'b0;
    capture    = 1'b0;
    set_err    = 1'b0;
    eval       = 1'b0;
    case (state)
      SETUP: begin
        if (phase) begin
          state_next = WAIT;
          clear      = 1'b1;
        end
      end
      WAIT: begin
        if (!phase) begin
          state_next = SETUP;
        end else if (ship_total == '0) begin
          state_next = DONE;
        end else if (guess_valid) begin
          if (is_onehot(sing_guess)) begin
            capture    = 1'b1;
            state_next = EVAL;
          end else begin
            set_err = 1'b1;
          end
        end
      end
      EVAL: begin
        eval = 1'b1;
        if (!phase) begin
          state_next = SETUP;
        end else if (hit_cnt_upd == ship_total) begin
          state_next = DONE;
        end else begin
          state_next = WAIT;
        end
      end
      DONE: begin
        if (!phase) begin
          state_next = SETUP;
        end
      end
      default: state_next = SETUP;
    endcase
  end

  assign busy      = (state == EVAL);
  assign game_over = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      ship_reg     <= '0;
      ship_total   <= '0;
      g_reg        <= '0;
      result_valid <= 1'b0;
      hit          <= 1'b0;
      repeat_guess <= 1'b0;
      err_onehot   <= 1'b0;
      hit_map      <= '0;
      miss_map     <= '0;
      hit_cnt      <= '0;
      miss_cnt     <= '0;
    end else begin
      result_valid <= eval;
      if (state == SETUP) begin
        ship_reg   <= ship_map;
        ship_total <= ship_pop;
      end
      // Boards survive a phase drop so the display keeps the final game.
      if (clear) begin
        hit_map    <= '0;
        miss_map   <= '0;
        hit_cnt    <= '0;
        miss_cnt   <= '0;
        err_onehot <= 1'b0;
      end
      if (set_err) begin
        err_onehot <= 1'b1;
      end
      if (capture) begin
        g_reg <= sing_guess;
      end
      if (eval) begin
        repeat_guess <= is_repeat;
        hit          <= is_hit;
        if (is_hit) begin
          hit_map <= hit_map | g_reg;
          hit_cnt <= hit_cnt_inc;
        end else if (!is_repeat) begin
          miss_map <= miss_map | g_reg;
          miss_cnt <= miss_cnt_inc;
        end
      end
    end
  end

`ifdef C_HIT_CHECKER_STREAK_EN
  logic [CNT_W-1:0] cur_streak;
  logic [CNT_W-1:0] cur_streak_inc;

  assign cur_streak_inc = (cur_streak < CNT_W'(CELLS)) ? cur_streak + CNT_W'(1) : cur_streak;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cur_streak  <= '0;
      best_streak <= '0;
    end else if (eval) begin
      if (is_hit) begin
        cur_streak <= cur_streak_inc;
        if (cur_streak_inc > best_streak) begin
          best_streak <= cur_streak_inc;
        end
      end else if (!is_repeat) begin
        cur_streak <= '0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_c_hit_checker.sv
// Scoreboard bench for c_hit_checker: expected results queued at strobe time, compared on result_valid.
module tb_c_hit_checker;
  import battleship_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             phase;
  logic [CELLS-1:0] ship_map;
  logic             guess_valid;
  logic [CELLS-1:0] sing_guess;
  logic             busy;
  logic             result_valid;
  logic             hit;
  logic             repeat_guess;
  logic             err_onehot;
  logic [CELLS-1:0] hit_map;
  logic [CELLS-1:0] miss_map;
  logic [CNT_W-1:0] hit_cnt;
  logic [CNT_W-1:0] miss_cnt;
  logic             game_over;
`ifdef C_HIT_CHECKER_STREAK_EN
  logic [CNT_W-1:0] best_streak;
`endif

  c_hit_checker dut (
    .clk          (clk),
    .rst          (rst),
    .phase        (phase),
    .ship_map     (ship_map),
    .guess_valid  (guess_valid),
    .sing_guess   (sing_guess),
    .busy         (busy),
    .result_valid (result_valid),
    .hit          (hit),
    .repeat_guess (repeat_guess),
    .err_onehot   (err_onehot),
    .hit_map      (hit_map),
    .miss_map     (miss_map),
    .hit_cnt      (hit_cnt),
    .miss_cnt     (miss_cnt),
    .game_over    (game_over)
`ifdef C_HIT_CHECKER_STREAK_EN
    ,
    .best_streak  (best_streak)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             hit;
    logic             rep;
    logic [CNT_W-1:0] hc;
    logic [CNT_W-1:0] mc;
    logic [CELLS-1:0] hm;
    logic [CELLS-1:0] mm;
  } exp_t;

  exp_t exp_q[$];

  int unsigned assertions = 0;
  int unsigned failures   = 0;

  logic [CELLS-1:0] m_ship;
  logic [CELLS-1:0] m_hit_map;
  logic [CELLS-1:0] m_miss_map;
  logic [CNT_W-1:0] m_hit_cnt;
  logic [CNT_W-1:0] m_miss_cnt;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assertions++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_hit_map  = '0;
    m_miss_map = '0;
    m_hit_cnt  = '0;
    m_miss_cnt = '0;
  endtask

  task automatic push_expect(input logic [CELLS-1:0] g);
    exp_t e;
    e.rep = |(g & (m_hit_map | m_miss_map));
    e.hit = !e.rep && |(g & m_ship);
    if (e.hit) begin
      m_hit_map = m_hit_map | g;
      m_hit_cnt = m_hit_cnt + 1'b1;
    end else if (!e.rep) begin
      m_miss_map = m_miss_map | g;
      m_miss_cnt = m_miss_cnt + 1'b1;
    end
    e.hc = m_hit_cnt;
    e.mc = m_miss_cnt;
    e.hm = m_hit_map;
    e.mm = m_miss_map;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input int unsigned max_cycles);
    for (int unsigned i = 0; i < max_cycles; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    check_eq("result_arrived", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic guess(input logic [CELLS-1:0] g);
    guess_valid = 1'b1;
    sing_guess  = g;
    push_expect(g);
    tick();
    guess_valid = 1'b0;
    wait_drain(4);
  endtask

  always @(negedge clk) begin
    if (result_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_result", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("hit", 64'(hit), 64'(e.hit));
        check_eq("repeat_guess", 64'(repeat_guess), 64'(e.rep));
        check_eq("hit_cnt", 64'(hit_cnt), 64'(e.hc));
        check_eq("miss_cnt", 64'(miss_cnt), 64'(e.mc));
        check_eq("hit_map", 64'(hit_map), 64'(e.hm));
        check_eq("miss_map", 64'(miss_map), 64'(e.mm));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_outputs"},
             64'({busy, result_valid, hit, repeat_guess, err_onehot, game_over}), 64'd0);
    check_eq({tag, "_maps"}, 64'({hit_map, miss_map}), 64'd0);
    check_eq({tag, "_cnts"}, 64'({hit_cnt, miss_cnt}), 64'd0);
  endtask

  initial begin
    rst         = 1'b1;
    phase       = 1'b0;
    ship_map    = 28'h000_0060;
    guess_valid = 1'b0;
    sing_guess  = '0;
    m_ship      = 28'h000_0060;
    model_clear();
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Game start: cells 5 and 6 hold ships.
    phase = 1'b1;
    tick();
    check_eq("wait_not_over", 64'(game_over), 64'd0);
    guess(CELLS'(1) << 5);
    guess(CELLS'(1) << 16);
    guess(CELLS'(1) << 16);

    // Back-to-back strobes: the second one arrives while busy and is dropped.
    guess_valid = 1'b1;
    sing_guess  = CELLS'(1) << 7;
    push_expect(sing_guess);
    tick();
    check_eq("busy_in_eval", 64'(busy), 64'd1);
    tick();
    guess_valid = 1'b0;
    wait_drain(4);
    tick();
    check_eq("busy_drop_miss_cnt", 64'(miss_cnt), 64'd2);
    check_eq("busy_no_err", 64'(err_onehot), 64'd0);

    // Non-one-hot strobes raise the sticky error and produce no result.
    guess_valid = 1'b1;
    sing_guess  = 28'h000_0003;
    tick();
    sing_guess  = '0;
    tick();
    guess_valid = 1'b0;
    tick();
    tick();
    check_eq("err_onehot_set", 64'(err_onehot), 64'd1);
    check_eq("err_cnts", 64'({hit_cnt, miss_cnt}), 64'({m_hit_cnt, m_miss_cnt}));

    guess(CELLS'(1) << 6);
    check_eq("game_over", 64'(game_over), 64'd1);

    guess_valid = 1'b1;
    sing_guess  = CELLS'(1) << 2;
    tick();
    guess_valid = 1'b0;
    tick();
    tick();
    check_eq("done_frozen_hit_cnt", 64'(hit_cnt), 64'd2);
    check_eq("done_frozen_miss_cnt", 64'(miss_cnt), 64'(m_miss_cnt));

    // Phase drop keeps the boards until the next phase rise.
    phase = 1'b0;
    tick();
    tick();
    check_eq("setup_not_over", 64'(game_over), 64'd0);
    check_eq("held_hit_map", 64'(hit_map), 64'h60);
    check_eq("held_miss_map", 64'(miss_map), 64'(m_miss_map));
    check_eq("held_err", 64'(err_onehot), 64'd1);
    phase = 1'b1;
    tick();
    model_clear();
    check_eq("rise_clear_maps", 64'({hit_map, miss_map}), 64'd0);
    check_eq("rise_clear_cnts", 64'({hit_cnt, miss_cnt}), 64'd0);
    check_eq("rise_clear_err", 64'(err_onehot), 64'd0);

    // Reset lands in the EVAL cycle: no result pulse, everything cleared.
    guess_valid = 1'b1;
    sing_guess  = CELLS'(1) << 5;
    tick();
    guess_valid = 1'b0;
    check_eq("eval_busy", 64'(busy), 64'd1);
    rst   = 1'b1;
    phase = 1'b0;
    tick();
    check_all_zero("rst_in_eval");
    rst = 1'b0;
    tick();
    check_all_zero("after_rst");

    // Empty ship map: game ends one cycle after entering WAIT.
    ship_map = '0;
    m_ship   = '0;
    tick();
    phase = 1'b1;
    tick();
    check_eq("empty_wait", 64'(game_over), 64'd0);
    tick();
    check_eq("empty_game_over", 64'(game_over), 64'd1);
    check_eq("empty_no_result", 64'(exp_q.size()), 64'd0);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/c_hit_checker.md
Name: c_hit_checker

Overview:
- Downstream consumer of the computer guess generator.
- Latches the player's ship map at game-phase entry, then evaluates each one-hot single-cell computer guess against that map.
- Maintains cumulative hit/miss boards and counts, and raises game_over once every ship cell has been hit.
- Outputs drive the player-board display and the turn/score logic.

Parameters:
- CELLS, 28, number of board cells (one bit per cell).
- CNT_W, 5, width of the hit/miss/ship counters; must satisfy 2^CNT_W > CELLS.

Ports:
- clk  input  1  system clock (4 Hz game clock domain).
- rst  input  1  synchronous, active-high reset.
- phase  input  1  1 = game phase, 0 = setup phase.
- ship_map  input  CELLS  player ship placement, bit i = ship on cell i.
- guess_valid  input  1  one-cycle strobe: sing_guess holds a new guess.
- sing_guess  input  CELLS  current single guess, expected one-hot.
- busy  output  1  high while in EVAL; strobes arriving now are dropped.
- result_valid  output  1  one-cycle pulse: hit/repeat are valid.
- hit  output  1  the last evaluated guess hit a ship cell.
- repeat_guess  output  1  the last evaluated guess was already on the hit or miss board.
- err_onehot  output  1  sticky; a strobed guess was not one-hot.
- hit_map  output  CELLS  cumulative hit cells.
- miss_map  output  CELLS  cumulative miss cells.
- hit_cnt  output  CNT_W  number of hits.
- miss_cnt  output  CNT_W  number of misses.
- game_over  output  1  all latched ship cells have been hit.

Behaviour:
- Reset (rst=1 at posedge clk):
  - All outputs 0.
  - ship_reg and ship_total 0.
  - State goes to SETUP.
- States are SETUP, WAIT, EVAL, DONE.
- SETUP:
  - ship_reg <= ship_map every cycle.
  - ship_total <= popcount(ship_map).
  - When phase=1, go to WAIT and clear hit_map, miss_map, both counts and err_onehot.
- WAIT:
  - On guess_valid=1: capture sing_guess into g_reg and go to EVAL.
  - If the capture is not one-hot (zero bits or more than one bit set): set err_onehot, do not capture, stay in WAIT.
- EVAL (single cycle, busy=1):
  - If g_reg & (hit_map | miss_map) is nonzero: result_valid=1, repeat_guess=1, hit=0; maps and counts unchanged.
  - Else if g_reg & ship_reg is nonzero: hit_map |= g_reg, hit_cnt++, hit=1.
  - Else: miss_map |= g_reg, miss_cnt++, hit=0.
  - In all cases result_valid pulses for this cycle. Go to DONE if the updated hit_cnt == ship_total, otherwise go to WAIT.
- Latency: strobe at posedge N, result registered at N+1, result_valid observed high in the cycle after posedge N+1.
- DONE:
  - game_over=1; maps and counts frozen; guess_valid ignored.
  - Leaves only via phase=0 or rst.
- ship_total == 0: WAIT goes to DONE on its first cycle with no guess required.
- phase falls to 0 in any state: go to SETUP next cycle. Maps and counts hold until the next phase rise clears them, so the display keeps the final board.
- guess_valid while busy=1: dropped. No queueing and no error flag.
- rst together with guess_valid, or rst mid-EVAL: reset wins; no result_valid pulse.
- Counters saturate at CELLS; by construction they cannot exceed it.
- result_valid, hit and repeat_guess are registered. hit and repeat_guess hold their value until the next evaluation.

Optional Feature:
- Macro: C_HIT_CHECKER_STREAK_EN.
- When defined, the block adds output best_streak [CNT_W-1:0] and an internal cur_streak:
  - A non-repeat hit increments cur_streak.
  - A miss clears cur_streak.
  - A repeat leaves cur_streak unchanged.
  - best_streak = max(best_streak, cur_streak) is updated in the same cycle as the hit.
  - Both are cleared on rst and at phase rise.
- When undefined, the port and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package battleship_pkg holds:
  - CELLS=28 and CNT_W=5.
  - The state enum {SETUP, WAIT, EVAL, DONE}.
  - A function is_onehot(CELLS-bit).
- One sub-module, popcount_cells: a combinational CELLS-to-CNT_W population count, instantiated for ship_total.

Test Plan:
- Hit and miss:
  - Stimulus: ship_map=28'h000_0060 (cells 5,6); phase 0->1; guesses 1<<5, then 1<<16.
  - Response: first result hit=1, hit_cnt=1; second result hit=0, miss_cnt=1, miss_map=28'h001_0000.
- Game over:
  - Stimulus: same map; guesses 1<<5, 1<<6.
  - Response: game_over=1 after the second result; a further strobe (1<<2) leaves hit_cnt=2, miss_cnt=0.
- Repeat guess:
  - Stimulus: guess 1<<16 twice.
  - Response: second result has repeat_guess=1, hit=0, miss_cnt still 1.
- Invalid guess:
  - Stimulus: strobes with sing_guess=28'h000_0003 and with 0.
  - Response: err_onehot=1, no result_valid, counts unchanged; err_onehot clears at the next phase rise.
- Reset and phase:
  - Stimulus: assert rst in the EVAL cycle.
  - Response: all outputs 0, state SETUP.
  - Stimulus: drop phase in DONE.
  - Response: maps held; the next phase rise clears them.
- Busy and empty map:
  - Stimulus: guess_valid on back-to-back cycles.
  - Response: only the first strobe is evaluated.
  - Stimulus: ship_map=0, phase rise.
  - Response: game_over=1 one cycle after entering WAIT.
